// File: rtl/window_averager.sv
// -----------------------------------------------------------------------------
// window_averager
//
// Decimating integrate-and-dump mean placed after a free-running signed
// accumulator. Once every N = 2**p_LOG2_WINDOW sample events the running
// total is snapshotted. The previous snapshot is subtracted to form the window
// sum, and that sum is arithmetically shifted down by p_LOG2_WINDOW. The
// resulting mean is held on a registered valid/ready output.
//
// Ports
//   i_CLK           system clock, rising edge
//   i_RESET_N       synchronous active-low reset
//   i_CLK_ENABLE    sample strobe (same strobe as the upstream accumulator)
//   i_ACCUMULATION  signed running total, value before this enable's summand
//   i_RESTART       drop baseline and restart windowing; output untouched
//   i_READY         downstream accepts o_AVERAGE when high with o_VALID
//   o_AVERAGE       signed window mean (registered)
//   o_VALID         o_AVERAGE holds an unconsumed result
//   o_OVERRUN       sticky: a result was overwritten before acceptance
// -----------------------------------------------------------------------------
module window_averager #(
   parameter int p_DATA_WIDTH  = 8,
   parameter int p_LOG2_WINDOW = 2
) (
   input  logic                           i_CLK,
   input  logic                           i_RESET_N,
   input  logic                           i_CLK_ENABLE,
   input  logic signed [p_DATA_WIDTH-1:0] i_ACCUMULATION,
   input  logic                           i_RESTART,
   input  logic                           i_READY,
   output logic signed [p_DATA_WIDTH-1:0] o_AVERAGE,
   output logic                           o_VALID,
   output logic                           o_OVERRUN
);

   typedef enum logic {
      WAIT_BASE = 1'b0,
      RUN       = 1'b1
   } state_t;

   state_t                           state_q, state_d;
   logic [p_LOG2_WINDOW-1:0]         count_q, count_d;
   logic signed [p_DATA_WIDTH-1:0]   base_q, base_d;
   logic signed [p_DATA_WIDTH-1:0]   average_q, average_d;
   logic                             valid_q, valid_d;
   logic                             overrun_q, overrun_d;

   logic signed [p_DATA_WIDTH-1:0]   window_sum;
   logic signed [p_DATA_WIDTH-1:0]   window_mean;
   logic                             boundary;
   logic                             load;

   // Modular subtraction recovers the true window sum even when the upstream
   // total has wrapped, provided the sum itself fits in p_DATA_WIDTH signed.
   assign window_sum  = i_ACCUMULATION - base_q;
   // Arithmetic shift floors toward -inf (e.g. -5/4 -> -2).
   assign window_mean = window_sum >>> p_LOG2_WINDOW;

   // The counter width is exactly log2(N), so it wraps from N-1 to 0 for free.
   assign boundary = i_CLK_ENABLE && (count_q == '0);

   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path
      // leaves it unassigned; that is what keeps this block latch-free.
      state_d   = state_q;
      count_d   = count_q;
      base_d    = base_q;
      average_d = average_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      load      = 1'b0;

      // Restart wins over a coincident sample, which is simply discarded.
      if (i_RESTART) begin
         count_d = '0;
         state_d = WAIT_BASE;
      end else if (i_CLK_ENABLE) begin
         count_d = count_q + p_LOG2_WINDOW'(1);
         if (boundary) begin
            base_d  = i_ACCUMULATION;
            state_d = RUN;
            load    = (state_q == RUN);
         end
      end

      // Output register: a new result always wins; otherwise normal handshake.
      if (load) begin
         average_d = window_mean;
         valid_d   = 1'b1;
         if (valid_q && !i_READY) begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && i_READY) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_CLK) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge values regardless of statement order.
      if (!i_RESET_N) begin
         state_q   <= WAIT_BASE;
         count_q   <= '0;
         base_q    <= '0;
         average_q <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         base_q    <= base_d;
         average_q <= average_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign o_AVERAGE = average_q;
   assign o_VALID   = valid_q;
   assign o_OVERRUN = overrun_q;

endmodule

// File: tb/tb_window_averager.sv
// -----------------------------------------------------------------------------
// tb_window_averager
//
// Drives window_averager (8-bit data, window of 4) from a small accumulator
// model. Expected means are written as literals in a vector table, pushed to a
// scoreboard queue on the last sample of each window, and popped when the
// following boundary edge should present them on o_AVERAGE.
// -----------------------------------------------------------------------------
module tb_window_averager;

   localparam int W  = 8;
   localparam int LW = 2;

   logic                clk;
   logic                reset_n;
   logic                clk_enable;
   logic signed [W-1:0] accumulation;
   logic                restart;
   logic                ready;
   logic signed [W-1:0] average;
   logic                valid;
   logic                overrun;

   window_averager #(
      .p_DATA_WIDTH  (W),
      .p_LOG2_WINDOW (LW)
   ) dut (
      .i_CLK          (clk),
      .i_RESET_N      (reset_n),
      .i_CLK_ENABLE   (clk_enable),
      .i_ACCUMULATION (accumulation),
      .i_RESTART      (restart),
      .i_READY        (ready),
      .o_AVERAGE      (average),
      .o_VALID        (valid),
      .o_OVERRUN      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [0:3][7:0] s;    // four summands of one window
      logic [7:0]      mean; // expected floor(sum / 4)
   } vec_t;

   vec_t        vecs [8];
   logic [7:0]  exp_q [$];
   logic [7:0]  acc_m;       // upstream accumulator model
   int          checks;
   int          errors;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, take the edge, read outputs 1ns later.
   task automatic step(input logic en, input logic [7:0] s, input logic rst, input logic rdy);
      clk_enable   = en;
      accumulation = acc_m;
      restart      = rst;
      ready        = rdy;
      @(posedge clk);
      #1;
      if (en) acc_m = acc_m + s;
      clk_enable = 1'b0;
      restart    = 1'b0;
   endtask

   task automatic pop_check(input string name);
      logic [7:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty, got 0x%02h", name, average);
      end else begin
         e = exp_q.pop_front();
         check(name, average, e);
         check({name, "_valid"}, {7'd0, valid}, 8'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks       = 0;
      errors       = 0;
      acc_m        = 8'd0;
      reset_n      = 1'b0;
      clk_enable   = 1'b0;
      accumulation = '0;
      restart      = 1'b0;
      ready        = 1'b1;

      vecs[0] = '{s: {8'd3,   8'd3,   8'd3,   8'd3  }, mean: 8'd3  };
      vecs[1] = '{s: {8'd3,   8'd3,   8'd3,   8'd3  }, mean: 8'd3  };
      vecs[2] = '{s: {8'd1,   8'd1,   8'd1,   8'd2  }, mean: 8'd1  };
      vecs[3] = '{s: {8'hFF,  8'hFF,  8'hFF,  8'hFE }, mean: 8'hFE };  // -5 -> -2
      vecs[4] = '{s: {8'd31,  8'd31,  8'd31,  8'd32 }, mean: 8'd31 };  // 125
      vecs[5] = '{s: {8'hE0,  8'hE0,  8'hE0,  8'hE0 }, mean: 8'hE0 };  // -128 -> -32
      vecs[6] = '{s: {8'd0,   8'd0,   8'd0,   8'hFF }, mean: 8'hFF };  // -1 -> -1
      vecs[7] = '{s: {8'd0,   8'd1,   8'd2,   8'd0  }, mean: 8'd0  };  // 3 -> 0

      // Reset state
      step(1'b0, 8'd0, 1'b0, 1'b1);
      step(1'b0, 8'd0, 1'b0, 1'b1);
      check("reset_average", average, 8'd0);
      check("reset_valid",   {7'd0, valid},   8'd0);
      check("reset_overrun", {7'd0, overrun}, 8'd0);
      reset_n = 1'b1;

      // Table: back-to-back windows with i_READY=1
      for (int v = 0; v < 8; v++) begin
         for (int j = 0; j < 4; j++) begin
            step(1'b1, vecs[v].s[j], 1'b0, 1'b1);
            if (v > 0 && j == 0) pop_check($sformatf("table%0d", v - 1));
            if (v > 0 && j == 1) check($sformatf("table%0d_drop", v - 1), {7'd0, valid}, 8'd0);
            if (v == 0) check("first_window_no_output", {7'd0, valid}, 8'd0);
            if (j == 1 && v[0]) step(1'b0, 8'd0, 1'b0, 1'b1);  // idle cycle must hold state
            if (j == 3) exp_q.push_back(vecs[v].mean);
         end
      end
      step(1'b1, 8'd0, 1'b0, 1'b1);
      pop_check("table7");
      step(1'b0, 8'd0, 1'b0, 1'b1);
      check("table7_drop", {7'd0, valid}, 8'd0);

      // Simultaneous accept and load
      step(1'b0, 8'd0, 1'b1, 1'b0);
      for (int j = 0; j < 4; j++) step(1'b1, 8'd2, 1'b0, 1'b0);
      exp_q.push_back(8'd2);
      step(1'b1, 8'd6, 1'b0, 1'b0);
      pop_check("simul_first");
      for (int j = 0; j < 3; j++) step(1'b1, 8'd6, 1'b0, 1'b0);
      check("simul_hold", average, 8'd2);
      exp_q.push_back(8'd6);
      step(1'b1, 8'd0, 1'b0, 1'b1);
      pop_check("simul_load");
      check("simul_no_overrun", {7'd0, overrun}, 8'd0);
      step(1'b0, 8'd0, 1'b0, 1'b1);
      check("simul_drop", {7'd0, valid}, 8'd0);

      // Backpressure across two windows
      step(1'b0, 8'd0, 1'b1, 1'b0);
      for (int j = 0; j < 4; j++) step(1'b1, 8'd3, 1'b0, 1'b0);
      exp_q.push_back(8'd3);
      step(1'b1, 8'd5, 1'b0, 1'b0);
      pop_check("bp_first");
      for (int j = 0; j < 3; j++) step(1'b1, 8'd5, 1'b0, 1'b0);
      check("bp_held", average, 8'd3);
      check("bp_held_valid", {7'd0, valid}, 8'd1);
      check("bp_no_overrun_yet", {7'd0, overrun}, 8'd0);
      exp_q.push_back(8'd5);
      step(1'b1, 8'd0, 1'b0, 1'b0);
      pop_check("bp_overwrite");
      check("bp_overrun", {7'd0, overrun}, 8'd1);
      step(1'b0, 8'd0, 1'b0, 1'b1);
      check("bp_drop", {7'd0, valid}, 8'd0);
      check("bp_overrun_sticky", {7'd0, overrun}, 8'd1);

      // Wrap-around: baseline 120, four summands of 10
      step(1'b0, 8'd0, 1'b1, 1'b1);
      acc_m = 8'd120;
      for (int j = 0; j < 4; j++) step(1'b1, 8'd10, 1'b0, 1'b1);
      exp_q.push_back(8'd10);
      step(1'b1, 8'd0, 1'b0, 1'b1);
      pop_check("wrap");

      // Reset mid-window (two events in)
      step(1'b0, 8'd0, 1'b1, 1'b1);
      step(1'b1, 8'd4, 1'b0, 1'b1);
      step(1'b1, 8'd4, 1'b0, 1'b1);
      reset_n = 1'b0;
      step(1'b0, 8'd0, 1'b0, 1'b1);
      reset_n = 1'b1;
      check("rst2_average", average, 8'd0);
      check("rst2_valid",   {7'd0, valid},   8'd0);
      check("rst2_overrun", {7'd0, overrun}, 8'd0);
      for (int j = 0; j < 4; j++) step(1'b1, 8'd4, 1'b0, 1'b0);
      check("rst2_no_early", {7'd0, valid}, 8'd0);
      exp_q.push_back(8'd4);
      step(1'b1, 8'd0, 1'b0, 1'b0);
      pop_check("rst2_first");

      // Restart with a pending result; the coincident sample is discarded
      step(1'b1, 8'd7, 1'b1, 1'b0);
      check("restart_keep_avg",   average, 8'd4);
      check("restart_keep_valid", {7'd0, valid}, 8'd1);
      for (int j = 0; j < 4; j++) step(1'b1, 8'd1, 1'b0, 1'b0);
      check("restart_still_avg", average, 8'd4);
      exp_q.push_back(8'd1);
      step(1'b1, 8'd0, 1'b0, 1'b0);
      pop_check("restart_first");
      check("restart_overrun", {7'd0, overrun}, 8'd1);
      step(1'b0, 8'd0, 1'b0, 1'b1);
      check("restart_drop", {7'd0, valid}, 8'd0);
      check("scoreboard_empty", 8'(exp_q.size()), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/window_averager.md
# window_averager

Downstream stage for the signed accumulator. It snapshots the running accumulation once every 2^p_LOG2_WINDOW clock-enabled cycles and subtracts the previous snapshot to get the window sum. It then divides by the window length with an arithmetic shift and presents the average on a registered valid/ready output. It turns the free-running integrator into a decimated integrate-and-dump mean for the next consumer.

## Interface
- p_DATA_WIDTH, 8, width of i_ACCUMULATION and o_AVERAGE; must match the upstream accumulator
- p_LOG2_WINDOW, 2, log2 of window length N (N = 2^p_LOG2_WINDOW); range 1 to p_DATA_WIDTH-1
- i_CLK  input  1  system clock; all state changes on the rising edge
- i_RESET_N  input  1  one clock; reset is synchronous and active-low
- i_CLK_ENABLE  input  1  same enable strobe that drives the upstream accumulator; one enable = one sample
- i_ACCUMULATION  input  p_DATA_WIDTH  signed running total from the accumulator
- i_RESTART  input  1  drop baseline and restart windowing; does not disturb a pending output
- i_READY  input  1  downstream accepts o_AVERAGE when high together with o_VALID
- o_AVERAGE  output  p_DATA_WIDTH  signed window mean; registered
- o_VALID  output  1  o_AVERAGE holds an unconsumed result
- o_OVERRUN  output  1  sticky: a result was overwritten before it was accepted

## Operation
- **Reset** (i_RESET_N low at an edge):
  - o_AVERAGE=0, o_VALID=0, o_OVERRUN=0
  - window counter=0, baseline register=0
  - state=WAIT_BASE
- **Sample event:** a rising edge with i_CLK_ENABLE=1. i_ACCUMULATION is sampled on that edge. It is the total *before* that enable's summand is added upstream.
- **Window counter:**
  - Counts sample events from 0 to N-1, then wraps to 0.
  - A boundary is a sample event where the counter equals 0.
- **State WAIT_BASE:**
  - At a boundary: baseline <= i_ACCUMULATION, counter <= 1, go to RUN. No output is produced.
- **State RUN:**
  - At a boundary: D = i_ACCUMULATION - baseline, computed modulo 2^p_DATA_WIDTH. D equals the sum of the last N summands whenever that true sum fits in p_DATA_WIDTH signed.
  - Result = D >>> p_LOG2_WINDOW (arithmetic shift, floor toward -inf).
  - Baseline <= i_ACCUMULATION.
- **Result load:** the result is written to o_AVERAGE and o_VALID is set.
  - If o_VALID=1 and i_READY=0 on the same edge: overwrite with the newest result and set o_OVERRUN.
  - If o_VALID=1 and i_READY=1 on the same edge: load the new result, o_VALID stays 1, no overrun.
- **Handshake:**
  - o_VALID clears on an edge with o_VALID=1, i_READY=1 and no new result.
  - o_AVERAGE is stable while o_VALID=1 and no new result loads.
- **i_RESTART=1 at an edge:**
  - counter <= 0, go to WAIT_BASE.
  - Takes priority over a sample event on the same edge; that sample is discarded.
  - o_AVERAGE, o_VALID and o_OVERRUN are unaffected.
  - The system must pulse i_RESTART whenever the upstream accumulator is reset independently.
- **Priority:** i_RESET_N low > i_RESTART > sample event.
- i_CLK_ENABLE=0 with no restart: counter, baseline and state hold.

## Timing
- Latency is one edge. The boundary sample edge also loads o_AVERAGE and raises o_VALID, so they are visible in the following cycle.
- Throughput: at most one result per N sample events. First result arrives at the second boundary after reset or restart (the (N+1)th sample event).
- o_OVERRUN rises on the edge of the overwriting load and is cleared only by reset.
- Reset mid-window discards the partial window. The next sample event becomes the new baseline boundary.
- i_READY may be high while o_VALID=0; it has no effect.

## Test plan
- p_DATA_WIDTH=8, p_LOG2_WINDOW=2, accumulator fed summand 3 on every enable, i_READY=1:
  - baseline 0 at event 0; at event 4 (acc 12) o_AVERAGE=3, o_VALID=1 for one cycle.
  - Then 3 again at event 8 (acc 24).
- Floor rounding:
  - summands 1,1,1,2 -> D=5 -> o_AVERAGE=1.
  - summands -1,-1,-1,-2 -> D=-5 -> o_AVERAGE=-2 (0xFE).
- Wrap-around: baseline acc=120, four summands of 10 -> acc wraps to -96; D=40 -> o_AVERAGE=10.
- Backpressure with i_READY=0 across two windows:
  - first result 3 is held.
  - second window (summands 5) overwrites: o_AVERAGE=5, o_OVERRUN=1.
  - raise i_READY -> o_VALID drops next edge, o_OVERRUN stays 1.
- Simultaneous accept and load: o_VALID=1, i_READY=1 on a boundary edge -> new value loaded, o_VALID stays 1, o_OVERRUN stays 0.
- Reset and restart:
  - i_RESET_N low after 2 events of a window -> all outputs 0, state WAIT_BASE.
  - Next event is the baseline; first result after 4 more events.
  - i_RESTART with a pending result -> o_VALID and o_AVERAGE retained.
